// File: rtl/fpu_pkg.sv
// Shared types for the fp16 adder arbiter: operand width, fp16 word type,
// arbiter FSM state encoding and the id-width helper.
package fpu_pkg;

    localparam int FP16_W = 16;

    typedef logic [FP16_W-1:0] fp16_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Requester index width; a single requester still gets a 1-bit id.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: searches upward from last_grant+1 (mod N)
// and returns the first asserted request as one-hot and as an index.
module rr_arbiter
    import fpu_pkg::*;
#(
    parameter  int N    = 4,
    localparam int ID_W = id_width(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_last_grant,
    output logic [N-1:0]    o_grant_onehot,
    output logic [ID_W-1:0] o_grant_idx
);

    logic            w_found;
    logic [ID_W-1:0] w_idx;

    // Rotate-priority search; the first hit after the previous winner takes the grant.
    always_comb begin
        w_found        = 1'b0;
        w_idx          = '0;
        o_grant_onehot = '0;
        o_grant_idx    = '0;
        for (int i = 1; i <= N; i++) begin
            w_idx = ID_W'((int'(i_last_grant) + i) % N);
            if (!w_found && i_req[w_idx]) begin
                w_found                = 1'b1;
                o_grant_idx            = w_idx;
                o_grant_onehot[w_idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_add_arbiter.sv
// Shares one fixed-latency fp16 adder between NUM_REQ requesters.
// One operation in flight; the sum is returned with the requester id on a
// valid/ready response channel.
// Optional macro FPU_ADD_ARB_FLAGS_EN adds adder overflow/underflow flags,
// captured together with the sum.
//
// state | meaning
// IDLE  | arbitrate; grant one valid requester and capture its operands
// ISSUE | pulse add_en for one cycle with the captured operands
// WAIT  | count down the adder latency, capture the result at zero
// RESP  | hold the response until the consumer takes it
module fpu_add_arbiter
    import fpu_pkg::*;
#(
    parameter  int NUM_REQ       = 4,
    parameter  int ADDER_LATENCY = 4,
    localparam int ID_W          = id_width(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [FP16_W*NUM_REQ-1:0] i_req_a,
    input  logic [FP16_W*NUM_REQ-1:0] i_req_b,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_add_en,
    output logic [FP16_W-1:0]         o_add_a,
    output logic [FP16_W-1:0]         o_add_b,
    input  logic [FP16_W-1:0]         i_add_result,
    output logic                      o_rsp_valid,
    output logic [ID_W-1:0]           o_rsp_id,
    output logic [FP16_W-1:0]         o_rsp_data,
    input  logic                      i_rsp_ready
`ifdef FPU_ADD_ARB_FLAGS_EN
    ,
    input  logic                      i_add_overflow,
    input  logic                      i_add_underflow,
    output logic                      o_rsp_overflow,
    output logic                      o_rsp_underflow
`endif
);

    localparam int                CNT_W     = (ADDER_LATENCY > 1) ? $clog2(ADDER_LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(ADDER_LATENCY - 1);
    localparam logic [ID_W-1:0]   LAST_INIT = ID_W'(NUM_REQ - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    fp16_t             r_op_a;
    fp16_t             r_op_b;
    logic [ID_W-1:0]   r_op_id;
    logic [ID_W-1:0]   r_last_grant;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    fp16_t             r_rsp_data;

    logic [NUM_REQ-1:0] w_grant_onehot;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_any_req;
    fp16_t              w_sel_a;
    fp16_t              w_sel_b;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .i_req          (i_req_valid),
        .i_last_grant   (r_last_grant),
        .o_grant_onehot (w_grant_onehot),
        .o_grant_idx    (w_grant_idx)
    );

    assign w_any_req = |i_req_valid;

    // Operand mux driven by the one-hot grant.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_onehot[i]) begin
                w_sel_a = i_req_a[i*FP16_W +: FP16_W];
                w_sel_b = i_req_b[i*FP16_W +: FP16_W];
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and FSM-decoded outputs; ready only while arbitrating.
    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = '0;
        o_add_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    o_req_ready = w_grant_onehot;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                o_add_en    = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (r_rsp_valid && i_rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture, latency counter and response registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt        <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_id      <= '0;
            r_last_grant <= LAST_INIT;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_op_a       <= w_sel_a;
                        r_op_b       <= w_sel_b;
                        r_op_id      <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                    end
                end
                ISSUE: begin
                    r_cnt <= CNT_LOAD;
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_data  <= i_add_result;
                        r_rsp_id    <= r_op_id;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (r_rsp_valid && i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FPU_ADD_ARB_FLAGS_EN
    logic r_rsp_overflow;
    logic r_rsp_underflow;

    // Adder flags travel with the sum they belong to.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_overflow  <= 1'b0;
            r_rsp_underflow <= 1'b0;
        end else if (r_state == WAIT && r_cnt == '0) begin
            r_rsp_overflow  <= i_add_overflow;
            r_rsp_underflow <= i_add_underflow;
        end
    end

    assign o_rsp_overflow  = r_rsp_overflow;
    assign o_rsp_underflow = r_rsp_underflow;
`endif

    assign o_add_a     = r_op_a;
    assign o_add_b     = r_op_b;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Bench for fpu_add_arbiter with a fixed-latency fp16 adder stand-in that
// knows the handful of operand pairs used below.
module tb_fpu_add_arbiter;
    import fpu_pkg::*;

    localparam int NREQ = 4;
    localparam int LAT  = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid;
    logic [16*NREQ-1:0]   req_a;
    logic [16*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic                 add_en;
    logic [15:0]          add_a;
    logic [15:0]          add_b;
    logic [15:0]          add_result;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [15:0]          rsp_data;
    logic                 rsp_ready;
`ifdef FPU_ADD_ARB_FLAGS_EN
    logic                 add_ovf;
    logic                 add_unf;
    logic                 rsp_ovf;
    logic                 rsp_unf;
`endif

    always #5 clk = ~clk;

    fpu_add_arbiter #(
        .NUM_REQ       (NREQ),
        .ADDER_LATENCY (LAT)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .i_req_a        (req_a),
        .i_req_b        (req_b),
        .o_req_ready    (req_ready),
        .o_add_en       (add_en),
        .o_add_a        (add_a),
        .o_add_b        (add_b),
        .i_add_result   (add_result),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_id       (rsp_id),
        .o_rsp_data     (rsp_data),
        .i_rsp_ready    (rsp_ready)
`ifdef FPU_ADD_ARB_FLAGS_EN
        ,
        .i_add_overflow  (add_ovf),
        .i_add_underflow (add_unf),
        .o_rsp_overflow  (rsp_ovf),
        .o_rsp_underflow (rsp_unf)
`endif
    );

    // Adder stand-in: {overflow, underflow, sum} for the vectors in this bench.
    function automatic logic [17:0] fake_add(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h3C00_3C00: return {2'b00, 16'h4000};
            32'h3C00_4000: return {2'b00, 16'h4200};
            32'h4000_4000: return {2'b00, 16'h4400};
            32'h4000_4200: return {2'b00, 16'h4500};
            32'h7BFF_7BFF: return {2'b10, 16'h7C00};
            32'h0401_8400: return {2'b01, 16'h0001};
            default:       return {2'b00, 16'hFFFF};
        endcase
    endfunction

    logic [17:0] add_pipe [LAT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) add_pipe[i] <= '0;
        end else begin
            add_pipe[0] <= add_en ? fake_add(add_a, add_b) : 18'd0;
            for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
        end
    end

    assign add_result = add_pipe[LAT-1][15:0];
`ifdef FPU_ADD_ARB_FLAGS_EN
    assign add_ovf = add_pipe[LAT-1][17];
    assign add_unf = add_pipe[LAT-1][16];
`endif

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [15:0]    data;
        logic           ovf;
        logic           unf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: every accepted response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            chk("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
                chk("rsp_data", 64'(rsp_data), 64'(mon_e.data));
`ifdef FPU_ADD_ARB_FLAGS_EN
                chk("rsp_overflow", 64'(rsp_ovf), 64'(mon_e.ovf));
                chk("rsp_underflow", 64'(rsp_unf), 64'(mon_e.unf));
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [15:0] d, input logic o, input logic u);
        exp_t e;
        e.id   = IDW'(id);
        e.data = d;
        e.ovf  = o;
        e.unf  = u;
        sb_q.push_back(e);
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for an acceptance; the grant is checked, acceptance happens at the next edge.
    task automatic wait_grant(input logic [NREQ-1:0] exp_oh, input string nm,
                              output int t, output int waited);
        int w;
        w = 0;
        #1;
        while ((req_ready & req_valid) == '0 && w < 60) begin
            step();
            w++;
        end
        chk(nm, 64'(req_ready), 64'(exp_oh));
        t      = cyc;
        waited = w;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 100; i++) begin
            if (sb_q.size() == 0) break;
            step();
        end
        chk(nm, 64'(sb_q.size()), 64'd0);
    endtask

    logic [15:0] exp_sum [NREQ];

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t_prev, w, n;
        exp_sum[0] = 16'h4000;
        exp_sum[1] = 16'h4200;
        exp_sum[2] = 16'h4400;
        exp_sum[3] = 16'h4500;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;

        // Reset values
        #1;
        chk("reset_outputs", {req_ready, add_en, add_a, add_b, rsp_valid, rsp_id, rsp_data}, 64'd0);
        do_reset();

        // 1: single request, 1.0 + 1.0
        set_op(0, 16'h3C00, 16'h3C00);
        set_op(1, 16'h3C00, 16'h4000);
        set_op(2, 16'h4000, 16'h4000);
        set_op(3, 16'h4000, 16'h4200);
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        wait_grant(4'b0001, "t1_grant", t, w);
        chk("t1_ready_first_cycle", 64'(w), 64'd0);
        push(0, 16'h4000, 1'b0, 1'b0);
        step();
        req_valid = '0;
        chk("t1_add_en_issue", 64'(add_en), 64'd1);
        chk("t1_add_operands", {add_a, add_b}, 64'h3C00_3C00);
        n = 0;
        while (!rsp_valid && n < 30) begin
            step();
            n++;
            if (n == 1) chk("t1_add_en_single", 64'(add_en), 64'd0);
        end
        chk("t1_latency", 64'(n), 64'd5);
        step();
        chk("t1_rsp_one_cycle", 64'(rsp_valid), 64'd0);
        drain("t1_drain");

        // 2: all requesters valid -> strict rotation, 7 cycles apart
        do_reset();
        req_valid = 4'b1111;
        t_prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(NREQ'(1 << (k % NREQ)), "t2_rotation", t, w);
            push(k % NREQ, exp_sum[k % NREQ], 1'b0, 1'b0);
            if (k > 0) chk("t2_interval", 64'(t - t_prev), 64'd7);
            t_prev = t;
            step();
        end
        req_valid = '0;
        drain("t2_drain");

        // 3: consumer stalls for 10 cycles
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        wait_grant(4'b0001, "t3_grant", t, w);
        push(0, 16'h4000, 1'b0, 1'b0);
        step();
        req_valid = 4'b1111;
        n = 0;
        while (!rsp_valid && n < 30) begin
            step();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold", {rsp_valid, rsp_id, rsp_data, req_ready, add_en},
                {1'b1, 2'd0, 16'h4000, 4'b0000, 1'b0});
            step();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        drain("t3_drain");

        // 4: reset during WAIT discards the operation
        req_valid = 4'b0001;
        wait_grant(4'b0001, "t4_grant", t, w);
        step();
        req_valid = '0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("t4_reset_outputs", {req_ready, add_en, add_a, add_b, rsp_valid, rsp_id, rsp_data}, 64'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t4_no_stale_rsp", 64'(rsp_valid), 64'd0);
            step();
        end

        // 5: wrap search from last_grant=3
        req_valid = 4'b0100;
        wait_grant(4'b0100, "t5_grant2", t, w);
        push(2, 16'h4400, 1'b0, 1'b0);
        step();
        req_valid = 4'b0101;
        wait_grant(4'b0001, "t5_grant0", t, w);
        push(0, 16'h4000, 1'b0, 1'b0);
        step();
        req_valid = '0;
        drain("t5_drain");

        // 6: overflow and underflow vectors
        set_op(0, 16'h7BFF, 16'h7BFF);
        set_op(1, 16'h0401, 16'h8400);
        req_valid = 4'b0011;
        wait_grant(4'b0010, "t6_grant1", t, w);
        push(1, 16'h0001, 1'b0, 1'b1);
        step();
        req_valid = 4'b0001;
        wait_grant(4'b0001, "t6_grant0", t, w);
        push(0, 16'h7C00, 1'b1, 1'b0);
        step();
        req_valid = '0;
        drain("t6_drain");

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
